mem_byte_sequencer: RTL

Load/store sequencer between the pipeline MEM stage and the byte-wide asynchronous data memory (13-bit address, 8-bit data, rden/wren).
- Accepts one RV32 load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Performs it as 1, 2 or 4 little-endian byte cycles.
- Returns the sign- or zero-extended 32-bit load result with a one-cycle done pulse.
- Drives busy so the pipeline stalls while a request is in progress.

---
 rtl/mem_byte_sequencer_pkg.sv | 24 ++
 rtl/mem_byte_sequencer_if.sv | 31 +++
 rtl/mem_byte_sequencer_load_extend.sv | 19 +
 rtl/mem_byte_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_byte_sequencer_pkg.sv
// rtl/mem_byte_sequencer_pkg.sv - shared funct3 codes, FSM encoding and byte-count helper
package mem_seq_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [2:0] byte_count(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: byte_count = 3'd1;
            F3_H, F3_HU: byte_count = 3'd2;
            default:     byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// rtl/mem_byte_sequencer_if.sv - request/response and byte-memory signals of the sequencer
interface mem_byte_sequencer_if #(
    parameter int ADDR_W = 13,
    parameter int XLEN   = 32
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [XLEN-1:0]   rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [7:0]        mem_data_in;
    logic              mem_rden;
    logic              mem_wren;
    logic [7:0]        mem_data_out;

    // master: the sequencer itself (serves the pipeline, drives the memory)
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        output busy, done, err, rdata, mem_address, mem_data_in, mem_rden, mem_wren
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
        input  busy, done, err, rdata, mem_address, mem_data_in, mem_rden, mem_wren
    );
endinterface

// File: rtl/mem_byte_sequencer_load_extend.sv
// rtl/mem_byte_sequencer_load_extend.sv - sign/zero extension of the assembled load word
module load_extend
    import mem_seq_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] data_out
);
    always_comb begin
        data_out = data_in;
        case (funct3)
            F3_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
            F3_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
            F3_BU:   data_out = {24'h000000, data_in[7:0]};
            F3_HU:   data_out = {16'h0000, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end
endmodule

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - RV32 load/store as 1/2/4 byte cycles; MISALIGN_TRAP_EN traps misaligned H/W
module mem_byte_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int XLEN   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_byte_sequencer_if.master bus
);
    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   acc_q, acc_next;
    logic [XLEN-1:0]   rdata_q, ext_data;
    logic [1:0]        k_q, k_inc;
    logic              err_q;
    logic              accept, bad_req, last_byte;
    logic [ADDR_W-1:0] mem_address_q;
    logic [7:0]        mem_data_in_q;
    logic              mem_rden_q, mem_wren_q;

    assign accept    = (state_q == ST_IDLE || state_q == ST_DONE) && bus.req_valid;
    assign k_inc     = k_q + 2'd1;
    assign last_byte = ({1'b0, k_q} == (byte_count(f3_q) - 3'd1));

    always_comb begin
        bad_req = 1'b0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: bad_req = 1'b0;
            F3_BU, F3_HU:     bad_req = bus.req_we;
            default:          bad_req = 1'b1;
        endcase
`ifdef MISALIGN_TRAP_EN
        if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
            bad_req = 1'b1;
        if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
`endif
    end

    always_comb begin
        acc_next = acc_q;
        acc_next[8*k_q +: 8] = bus.mem_data_out;
    end

    load_extend u_load_extend (
        .data_in  (acc_next),
        .funct3   (f3_q),
        .data_out (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = bad_req ? ST_DONE : ST_ACCESS;
                else        state_d = ST_IDLE;
            end
            ST_ACCESS: if (last_byte) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
        bus.err  = (state_q == ST_DONE) && err_q;
    end

    // Memory strobes are registered so the async RAM sees stable controls all cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            addr_q        <= '0;
            wdata_q       <= '0;
            acc_q         <= '0;
            rdata_q       <= '0;
            k_q           <= 2'd0;
            err_q         <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= 8'h00;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
        end else if (accept) begin
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            acc_q         <= '0;
            rdata_q       <= '0;
            k_q           <= 2'd0;
            err_q         <= bad_req;
            mem_address_q <= bus.req_addr;
            mem_rden_q    <= !bad_req && !bus.req_we;
            mem_wren_q    <= !bad_req && bus.req_we;
            mem_data_in_q <= (!bad_req && bus.req_we) ? bus.req_wdata[7:0] : 8'h00;
        end else if (state_q == ST_ACCESS) begin
            k_q <= k_inc;
            if (!we_q) acc_q <= acc_next;
            if (last_byte) begin
                mem_rden_q    <= 1'b0;
                mem_wren_q    <= 1'b0;
                mem_data_in_q <= 8'h00;
                if (!we_q) rdata_q <= ext_data;
            end else begin
                mem_address_q <= addr_q + ADDR_W'(k_inc);
                mem_data_in_q <= we_q ? wdata_q[8*k_inc +: 8] : 8'h00;
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_rden    = mem_rden_q;
    assign bus.mem_wren    = mem_wren_q;

endmodule
